// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline (fetch and memory stages), the unified memory and the port arbiter.
// The arbiter uses the slave modport; the pipeline and memory side use master.
interface mem_port_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_be;
  logic [31:0] o_dm_rdata;
  logic        o_dm_valid;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata;
  logic        o_stall_fetch;
  logic        o_stall_mem;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be, i_mem_rdata,
    output o_if_rdata, o_if_valid, o_dm_rdata, o_dm_valid, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_be, o_stall_fetch, o_stall_mem
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be, i_mem_rdata,
    input  o_if_rdata, o_if_valid, o_dm_rdata, o_dm_valid, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_be, o_stall_fetch, o_stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. data, data priority with a starvation guard for fetch.
// Every access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [2:0] LAT   = 3'(MEM_LATENCY);
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_owner_dm;
  logic [2:0]  r_lat;
  logic [2:0]  r_starve;
  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        w_any_req;
  logic        w_dm_win;
  logic        w_if_valid;
  logic        w_dm_valid;

  assign w_any_req = bus.i_if_req | bus.i_dm_req;
  assign w_dm_win  = bus.i_dm_req & (~bus.i_if_req | (r_starve < LIMIT));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_lat == 3'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = 32'h0;
    bus.o_mem_wdata = 32'h0;
    bus.o_mem_be    = 4'h0;
    if (r_state == S_ISSUE) begin
      bus.o_mem_en    = 1'b1;
      bus.o_mem_we    = r_req_we;
      bus.o_mem_addr  = r_req_addr;
      bus.o_mem_wdata = r_req_wdata;
      bus.o_mem_be    = r_req_be;
    end
    w_if_valid = (r_state == S_RESP) & ~r_owner_dm;
    w_dm_valid = (r_state == S_RESP) &  r_owner_dm;
  end

  // Request latch, counters and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_dm  <= 1'b0;
      r_lat       <= 3'd0;
      r_starve    <= 3'd0;
      r_req_we    <= 1'b0;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_req_be    <= 4'h0;
      r_if_rdata  <= 32'h0;
      r_dm_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req) begin
          r_owner_dm <= w_dm_win;
          if (w_dm_win) begin
            r_req_we    <= bus.i_dm_we;
            r_req_addr  <= bus.i_dm_addr;
            r_req_wdata <= bus.i_dm_wdata;
            r_req_be    <= bus.i_dm_we ? bus.i_dm_be : 4'hF;
            if (bus.i_if_req && r_starve != LIMIT) r_starve <= r_starve + 3'd1;
          end else begin
            r_req_we    <= 1'b0;
            r_req_addr  <= bus.i_if_addr;
            r_req_wdata <= 32'h0;
            r_req_be    <= 4'hF;
            r_starve    <= 3'd0;
          end
        end
        S_ISSUE: r_lat <= LAT;
        S_WAIT: begin
          r_lat <= r_lat - 3'd1;
          if (r_lat == 3'd1) begin
            if (r_owner_dm) r_dm_rdata <= r_req_we ? 32'h0 : bus.i_mem_rdata;
            else            r_if_rdata <= bus.i_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_if_rdata    = r_if_rdata;
  assign bus.o_dm_rdata    = r_dm_rdata;
  assign bus.o_if_valid    = w_if_valid;
  assign bus.o_dm_valid    = w_dm_valid;
  assign bus.o_stall_fetch = bus.i_if_req & ~w_if_valid;
  assign bus.o_stall_mem   = bus.i_dm_req & ~w_dm_valid;
endmodule
